dma_copy: RTL and testbench
===========================

Name: dma_copy

Overview:
- Memory-to-memory copy engine; acts as an initiator (master) on the common memory bus, driving the same request/ready/fault protocol that the SoC's RAM, LED, UART, timer and flash peripherals respond to.
- Also exposes a small responder register window so the CPU can program source, destination and length, then start a transfer.
- Sits beside rv32 as an additional bus initiator, behind the bus arbiter.
- Its register window is decoded at 0x0004_0000–0x0004_000F in the top-level casez map.

Parameters:
- LEN_WIDTH, 16, width of the word-count register; maximum transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- address_in  input  32  responder bus address; bits [3:2] select the register
- sel_in  input  1  responder select from the top-level decode
- read_in  input  1  responder read strobe
- read_value_out  output  32  register read data; 0 when sel_in is low, because the top level ORs all responders
- write_mask_in  input  4  responder byte-write mask
- write_value_in  input  32  responder write data
- ready_out  output  1  responder ready
- address_out  output  32  initiator address, always word-aligned
- read_out  output  1  initiator read request
- write_out  output  1  initiator write request
- write_mask_out  output  4  initiator byte mask
- write_value_out  output  32  initiator write data
- read_value_in  input  32  initiator read data
- ready_in  input  1  initiator transfer complete
- fault_in  input  1  initiator transfer faulted; valid only with ready_in
- busy_out  output  1  engine active; for the top level and interrupt use

Behaviour:
- Reset (reset low, async):
  - SRC, DST and LEN are 0; state IDLE; done and error are 0.
  - All initiator outputs are 0; busy_out is 0; read_value_out is 0.
- Register map (address_in[3:2]):
  - 0 SRC
  - 1 DST
  - 2 LEN (low LEN_WIDTH bits; upper bits read 0)
  - 3 CTRL/STATUS
- Register writes:
  - Happen on a clk edge when sel_in is high and the write mask is nonzero; each byte is honoured per write_mask_in.
  - SRC/DST bits [1:0] are forced to 0 on write.
  - Writes to SRC, DST or LEN while busy are ignored.
- CTRL/STATUS:
  - Write bit0=1 (with mask[0]) is start.
  - Read returns {29'b0, error, done, busy}.
- Responder handshake:
  - ready_out = sel_in (combinational, zero wait).
  - read_value_out is combinational from address_in when sel_in is high.
- Start:
  - Start while busy is ignored.
  - Start in IDLE clears done and error, then copies SRC, DST and LEN into the working counters cur_src, cur_dst and remaining.
  - If LEN == 0: done is set the next cycle with no bus traffic.
  - Otherwise the FSM enters RD, and read_out rises in the cycle after the start write.
- FSM states: IDLE, RD, WR.
  - IDLE: all initiator strobes are 0.
  - RD:
    - Drives read_out=1, address_out=cur_src, write_mask_out=0.
    - Holds these stable until ready_in.
    - On ready_in with fault_in: set error, go to IDLE.
    - On ready_in without fault: latch read_value_in into the data register, go to WR.
  - WR:
    - Drives write_out=1, address_out=cur_dst, write_mask_out=4'b1111, write_value_out=data register.
    - Holds until ready_in.
    - On fault: set error, go to IDLE.
    - Otherwise: cur_src += 4, cur_dst += 4, remaining -= 1.
    - If remaining was 1: set done, go to IDLE; else go to RD.
- Bus rules:
  - read_out and write_out are never both high.
  - Requests are registered, never combinational from ready_in.
  - With a zero-wait responder, each word costs 2 cycles.
- Boundaries:
  - Address increments wrap modulo 2^32.
  - Overlapping source/destination ranges are copied in ascending order, with no overlap correction.
  - A fault terminates the transfer immediately. The words already written stay written; the registers are not updated. Status shows done=0, error=1.
  - Reset mid-transfer aborts immediately: strobes drop asynchronously.
  - A register read during busy returns the programmed SRC/DST/LEN, not the working counters.
- busy_out = (state != IDLE).

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, RD, WR);
  - register offset constants (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3);
  - status bit positions.
- Single module, no sub-module; the register file and FSM share counters too tightly to justify a split.

Test Plan:
- Program SRC=0x100, DST=0x200, LEN=3 with a zero-wait RAM model preloaded with 0xA1, 0xB2, 0xC3, then start -> reads 0x100/0x104/0x108 alternate with writes 0x200/0x204/0x208, mask 4'b1111; done=1 after 6 bus cycles; status reads 0x2.
- LEN=0, then start -> no read_out/write_out ever asserted; status reads 0x2 the cycle after start.
- Responder inserts 3 wait cycles per access -> address_out, strobes and write_value_out stay stable until ready_in; data is still correct.
- fault_in with ready_in on the 2nd read of LEN=4 -> exactly one write occurred; FSM goes to IDLE; status reads 0x4; a second start clears error.
- During busy, write SRC=0xDEAD and issue start again -> SRC still reads its old value; the transfer is unaffected.
- Assert reset low mid-WR -> read_out, write_out and busy_out go to 0 without waiting for a clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy engine: FSM states, register offsets
// and status bit positions.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  localparam int CTRL_START = 0;

endpackage

// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy engine: a responder register window for
// programming plus an initiator port that alternates single-word reads and writes.
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic        busy_out
);

  state_t                 state;
  logic [31:0]            src_reg, dst_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [31:0]            cur_src, cur_dst;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [31:0]            data_reg;
  logic                   done, error;

  logic [1:0]  reg_sel;
  logic        reg_wr;
  logic        start;
  logic [31:0] status;
  logic [31:0] src_merged, dst_merged, len_merged;

  // Only the word-select bits matter; the window decode happens at the top level.
  logic unused_ok;
  assign unused_ok = ^{read_in, address_in[31:4], address_in[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  assign reg_sel   = address_in[3:2];
  assign reg_wr    = sel_in && (write_mask_in != 4'b0000);
  assign start     = reg_wr && (reg_sel == REG_CTRL) && write_mask_in[CTRL_START]
                     && write_value_in[CTRL_START];
  assign busy_out  = (state != IDLE);
  assign ready_out = sel_in;

  assign src_merged = merge_bytes(src_reg, write_value_in, write_mask_in);
  assign dst_merged = merge_bytes(dst_reg, write_value_in, write_mask_in);
  assign len_merged = merge_bytes(32'(len_reg), write_value_in, write_mask_in);

  assign write_value_out = data_reg;

  always_comb begin
    status              = '0;
    status[STAT_BUSY]   = busy_out;
    status[STAT_DONE]   = done;
    status[STAT_ERROR]  = error;
    read_value_out      = '0;
    if (sel_in) begin
      case (reg_sel)
        REG_SRC:  read_value_out = src_reg;
        REG_DST:  read_value_out = dst_reg;
        REG_LEN:  read_value_out = 32'(len_reg);
        default:  read_value_out = status;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      cur_src        <= '0;
      cur_dst        <= '0;
      remaining      <= '0;
      data_reg       <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      address_out    <= '0;
      read_out       <= 1'b0;
      write_out      <= 1'b0;
      write_mask_out <= '0;
    end else begin
      // Programmed registers stay frozen while a transfer runs.
      if (reg_wr && !busy_out) begin
        case (reg_sel)
          REG_SRC: src_reg <= {src_merged[31:2], 2'b00};
          REG_DST: dst_reg <= {dst_merged[31:2], 2'b00};
          REG_LEN: len_reg <= len_merged[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cur_src   <= src_reg;
            cur_dst   <= dst_reg;
            remaining <= len_reg;
            if (len_reg == '0) begin
              done <= 1'b1;
            end else begin
              state          <= RD;
              read_out       <= 1'b1;
              address_out    <= src_reg;
              write_mask_out <= 4'b0000;
            end
          end
        end
        RD: begin
          if (ready_in) begin
            read_out <= 1'b0;
            if (fault_in) begin
              error       <= 1'b1;
              state       <= IDLE;
              address_out <= '0;
            end else begin
              data_reg       <= read_value_in;
              state          <= WR;
              write_out      <= 1'b1;
              address_out    <= cur_dst;
              write_mask_out <= 4'b1111;
            end
          end
        end
        WR: begin
          if (ready_in) begin
            write_out      <= 1'b0;
            write_mask_out <= 4'b0000;
            if (fault_in) begin
              error       <= 1'b1;
              state       <= IDLE;
              address_out <= '0;
            end else begin
              cur_src   <= cur_src + 32'd4;
              cur_dst   <= cur_dst + 32'd4;
              remaining <= remaining - LEN_WIDTH'(1);
              if (remaining == LEN_WIDTH'(1)) begin
                done        <= 1'b1;
                state       <= IDLE;
                address_out <= '0;
              end else begin
                state       <= RD;
                read_out    <= 1'b1;
                address_out <= cur_src + 32'd4;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: stimulus queues expected bus beats, a monitor
// compares every completed initiator beat against them.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;
  logic        busy_out;

  always #5 clk = ~clk;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
    .busy_out(busy_out)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       sb[$];
  beat_t       e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:1023];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  int          wr_count = 0;
  int          req_seen = 0;

  // Memory responder with a configurable number of wait cycles per access.
  assign ready_in      = (read_out || write_out) && (wcnt == wait_cfg);
  assign fault_in      = ready_in && read_out && fault_en && (address_out == fault_addr);
  assign read_value_in = mem[address_out[11:2]];

  always @(posedge clk) begin
    if (read_out || write_out) begin
      if (ready_in) begin
        wcnt <= 0;
        if (write_out) begin
          mem[address_out[11:2]] = write_value_out;
          wr_count++;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: request stability while waiting, and scoreboard pop on each completed beat.
  logic        in_req = 1'b0;
  logic [31:0] h_addr, h_data;
  logic        h_rd, h_wr;

  always @(negedge clk) begin
    if (reset && (read_out || write_out)) begin
      req_seen++;
      check32("one_strobe", {31'b0, read_out & write_out}, 32'h0);
      if (in_req) begin
        check32("hold_addr", address_out, h_addr);
        check32("hold_kind", {30'b0, read_out, write_out}, {30'b0, h_rd, h_wr});
        if (write_out) check32("hold_wdata", write_value_out, h_data);
      end else begin
        in_req = 1'b1;
        h_addr = address_out;
        h_rd   = read_out;
        h_wr   = write_out;
        h_data = write_value_out;
      end
      if (ready_in) begin
        in_req = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%08h wr=%0b, expected none", address_out, write_out);
        end else begin
          e = sb.pop_front();
          check32("beat_kind", {31'b0, write_out}, {31'b0, e.wr});
          check32("beat_addr", address_out, e.addr);
          check32("beat_mask", {28'b0, write_mask_out}, e.wr ? 32'hF : 32'h0);
          if (e.wr) check32("beat_data", write_value_out, e.data);
        end
      end
    end else begin
      in_req = 1'b0;
    end
  end

  function automatic logic [31:0] reg_addr(input logic [1:0] idx);
    return 32'h0004_0000 | {28'b0, idx, 2'b00};
  endfunction

  task automatic reg_write(input logic [1:0] idx, input logic [31:0] val, input logic [3:0] mask);
    @(negedge clk);
    sel_in = 1'b1;
    address_in = reg_addr(idx);
    write_mask_in = mask;
    write_value_in = val;
    @(posedge clk);
    #1;
    sel_in = 1'b0;
    write_mask_in = 4'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] idx, input logic [31:0] exp);
    @(negedge clk);
    sel_in = 1'b1;
    read_in = 1'b1;
    address_in = reg_addr(idx);
    #1;
    check32(name, read_value_out, exp);
    #1;
    sel_in = 1'b0;
    read_in = 1'b0;
  endtask

  task automatic push_beat(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    beat_t b;
    b.wr = wr;
    b.addr = addr;
    b.data = data;
    sb.push_back(b);
  endtask

  task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] s, d;
    for (int i = 0; i < n; i++) begin
      s = src + 32'(4 * i);
      d = dst + 32'(4 * i);
      push_beat(1'b0, s, 32'h0);
      push_beat(1'b1, d, mem[s[11:2]]);
    end
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy_out && cyc < budget) begin
      cyc++;
      @(negedge clk);
    end
    if (busy_out) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", cyc);
    end
  endtask

  int cyc;
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_strobes", {29'b0, read_out, write_out, busy_out}, 32'h0);
    check32("rst_addr", address_out, 32'h0);
    reset = 1'b1;
    check_reg("rst_src", 2'd0, 32'h0);
    check_reg("rst_len", 2'd2, 32'h0);
    check_reg("rst_status", 2'd3, 32'h0);

    // Register file behaviour
    reg_write(2'd0, 32'h0000_0103, 4'hF);
    check_reg("src_align", 2'd0, 32'h0000_0100);
    reg_write(2'd1, 32'h1234_5678, 4'hF);
    reg_write(2'd1, 32'hAABB_CCDD, 4'b0100);
    check_reg("dst_bytemask", 2'd1, 32'h12BB_5678);
    reg_write(2'd2, 32'hFFFF_FFFF, 4'hF);
    check_reg("len_width", 2'd2, 32'h0000_FFFF);
    @(negedge clk);
    address_in = reg_addr(2'd0);
    #1;
    check32("rd_unselected", read_value_out, 32'h0);
    check32("ready_unselected", {31'b0, ready_out}, 32'h0);

    // Basic 3-word copy, zero wait
    mem[32'h100 >> 2] = 32'h0000_00A1;
    mem[32'h104 >> 2] = 32'h0000_00B2;
    mem[32'h108 >> 2] = 32'h0000_00C3;
    reg_write(2'd0, 32'h100, 4'hF);
    reg_write(2'd1, 32'h200, 4'hF);
    reg_write(2'd2, 32'd3, 4'hF);
    expect_copy(32'h100, 32'h200, 3);
    reg_write(2'd3, 32'h1, 4'b0001);
    wait_idle(100, cyc);
    check32("basic_cycles", 32'(cyc), 32'd6);
    check_reg("basic_status", 2'd3, 32'h2);
    check32("basic_mem2", mem[32'h208 >> 2], 32'h0000_00C3);
    check32("basic_sb_empty", 32'(sb.size()), 32'h0);

    // Zero length: done without bus traffic
    base = req_seen;
    reg_write(2'd2, 32'd0, 4'hF);
    reg_write(2'd3, 32'h1, 4'b0001);
    check_reg("len0_status", 2'd3, 32'h2);
    repeat (5) @(negedge clk);
    check32("len0_no_traffic", 32'(req_seen), 32'(base));

    // Three wait cycles per access
    wait_cfg = 3;
    mem[32'h300 >> 2] = 32'h1111_1111;
    mem[32'h304 >> 2] = 32'h2222_2222;
    reg_write(2'd0, 32'h300, 4'hF);
    reg_write(2'd1, 32'h400, 4'hF);
    reg_write(2'd2, 32'd2, 4'hF);
    expect_copy(32'h300, 32'h400, 2);
    reg_write(2'd3, 32'h1, 4'b0001);
    wait_idle(200, cyc);
    check32("wait_cycles", 32'(cyc), 32'd16);
    check32("wait_mem1", mem[32'h404 >> 2], 32'h2222_2222);
    check32("wait_sb_empty", 32'(sb.size()), 32'h0);
    wait_cfg = 0;

    // Fault on second read of a 4-word copy, then a clean restart
    for (int i = 0; i < 4; i++) mem[(32'h500 >> 2) + i] = 32'(i + 1);
    fault_en = 1'b1;
    fault_addr = 32'h504;
    reg_write(2'd0, 32'h500, 4'hF);
    reg_write(2'd1, 32'h600, 4'hF);
    reg_write(2'd2, 32'd4, 4'hF);
    push_beat(1'b0, 32'h500, 32'h0);
    push_beat(1'b1, 32'h600, 32'h1);
    push_beat(1'b0, 32'h504, 32'h0);
    base = wr_count;
    reg_write(2'd3, 32'h1, 4'b0001);
    wait_idle(100, cyc);
    check32("fault_writes", 32'(wr_count - base), 32'd1);
    check_reg("fault_status", 2'd3, 32'h4);
    check_reg("fault_src_kept", 2'd0, 32'h500);
    check32("fault_sb_empty", 32'(sb.size()), 32'h0);
    fault_en = 1'b0;
    expect_copy(32'h500, 32'h600, 4);
    reg_write(2'd3, 32'h1, 4'b0001);
    check_reg("restart_status", 2'd3, 32'h1);
    wait_idle(100, cyc);
    check_reg("restart_done", 2'd3, 32'h2);
    check32("restart_mem3", mem[32'h60C >> 2], 32'h4);

    // Register writes and start during busy are ignored
    wait_cfg = 1;
    mem[32'h700 >> 2] = 32'h7000_0001;
    mem[32'h704 >> 2] = 32'h7000_0002;
    mem[32'h708 >> 2] = 32'h7000_0003;
    reg_write(2'd0, 32'h700, 4'hF);
    reg_write(2'd1, 32'h800, 4'hF);
    reg_write(2'd2, 32'd3, 4'hF);
    expect_copy(32'h700, 32'h800, 3);
    reg_write(2'd3, 32'h1, 4'b0001);
    reg_write(2'd0, 32'h0000_DEAD, 4'hF);
    reg_write(2'd3, 32'h1, 4'b0001);
    check_reg("busy_src_kept", 2'd0, 32'h700);
    check_reg("busy_len_kept", 2'd2, 32'd3);
    wait_idle(200, cyc);
    check_reg("busy_done", 2'd3, 32'h2);
    check32("busy_mem2", mem[32'h808 >> 2], 32'h7000_0003);
    check32("busy_sb_empty", 32'(sb.size()), 32'h0);
    wait_cfg = 0;

    // Source address wraps modulo 2^32
    mem[32'hFFC >> 2] = 32'h5A5A_5A5A;
    mem[0] = 32'h0F0F_0F0F;
    reg_write(2'd0, 32'hFFFF_FFFC, 4'hF);
    reg_write(2'd1, 32'h900, 4'hF);
    reg_write(2'd2, 32'd2, 4'hF);
    expect_copy(32'hFFFF_FFFC, 32'h900, 2);
    reg_write(2'd3, 32'h1, 4'b0001);
    wait_idle(100, cyc);
    check32("wrap_mem0", mem[32'h900 >> 2], 32'h5A5A_5A5A);
    check32("wrap_mem1", mem[32'h904 >> 2], 32'h0F0F_0F0F);
    check32("wrap_sb_empty", 32'(sb.size()), 32'h0);

    // Asynchronous reset in the middle of a write
    reg_write(2'd0, 32'h100, 4'hF);
    reg_write(2'd1, 32'hA00, 4'hF);
    reg_write(2'd2, 32'd3, 4'hF);
    expect_copy(32'h100, 32'hA00, 3);
    reg_write(2'd3, 32'h1, 4'b0001);
    cyc = 0;
    @(negedge clk);
    while (!write_out && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check32("rstmid_saw_write", {31'b0, write_out}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check32("rstmid_async_drop", {29'b0, read_out, write_out, busy_out}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    check_reg("rstmid_src", 2'd0, 32'h0);
    check_reg("rstmid_dst", 2'd1, 32'h0);
    check_reg("rstmid_len", 2'd2, 32'h0);
    check_reg("rstmid_status", 2'd3, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
